// File: rtl/division_pkg.sv
// Shared definitions for the 8-bit divider and its multiply-add checker.
package division_pkg;

  localparam int DIV_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mult_add_datapath.sv
// Shift-add datapath: acc = remainder + quotient*divisor, one multiplier bit per step.
// Load on 'load', one iteration per 'step'; 'last' marks the final iteration (no backpressure).
module mult_add_datapath
  import division_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 load,
  input  logic                 step,
  input  logic [WIDTH-1:0]     quotient,
  input  logic [WIDTH-1:0]     divisor,
  input  logic [WIDTH-1:0]     remainder,
  output logic [2*WIDTH-1:0]   acc,
  output logic                 last
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0]   q;
  logic [WIDTH-1:0]   d;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] addend;

  // Partial product for the current multiplier bit, weighted by its position.
  assign addend = {{WIDTH{1'b0}}, d} << cnt;
  assign last   = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      q   <= '0;
      d   <= '0;
      acc <= '0;
      cnt <= '0;
    end else if (load) begin
      q   <= quotient;
      d   <= divisor;
      acc <= {{WIDTH{1'b0}}, remainder};
      cnt <= '0;
    end else if (step) begin
      if (q[0]) acc <= acc + addend;
      q   <= q >> 1;
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/division_check_mult.sv
// Rebuilds dividend = quotient*divisor + remainder and flags impossible triples.
// Latency WIDTH cycles from the start rising edge; launches during CALC are dropped, not queued.
module division_check_mult
  import division_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic                 sys_clock,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [WIDTH-1:0]     quotient_in,
  input  logic [WIDTH-1:0]     divisor_in,
  input  logic [WIDTH-1:0]     remainder_in,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   Dividend,
  output logic                 div_zero,
  output logic                 rem_err
);

  state_t state;
  logic   start_q;
  logic   launch;
  logic   last;

  assign launch = start & ~start_q & (state != CALC);

  mult_add_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk       (sys_clock),
    .resetn    (resetn),
    .load      (launch),
    .step      (state == CALC),
    .quotient  (quotient_in),
    .divisor   (divisor_in),
    .remainder (remainder_in),
    .acc       (Dividend),
    .last      (last)
  );

  // start_q resets high so a start held through reset release is not a launch.
  always_ff @(posedge sys_clock) begin
    if (!resetn) begin
      state    <= IDLE;
      start_q  <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      rem_err  <= 1'b0;
    end else begin
      start_q <= start;
      case (state)
        IDLE, DONE: begin
          if (launch) begin
            state    <= CALC;
            busy     <= 1'b1;
            done     <= 1'b0;
            div_zero <= (divisor_in == '0);
            rem_err  <= (remainder_in >= divisor_in);
          end
        end
        CALC: begin
          if (last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/division_check_mult.md
# division_check_mult

Sequential multiply-add unit performing the inverse of the 8-bit shift-subtract divider. Takes a quotient, divisor and remainder and rebuilds the dividend as `quotient*divisor + remainder` with a shift-add datapath. Flags triples that no legal division could produce. Shares the divider's `start`/`done` handshake and operand widths, so it can sit beside the divider on the same board wrapper (switches in, LEDs out) for round-trip checking.

## Interface
- `WIDTH`, default 8: operand width; the result is `2*WIDTH` bits.
- `sys_clock` in 1: system clock; all state changes on its rising edge.
- `resetn` in 1: synchronous, active-low reset.
- `start` in 1: level input; launch is on its rising edge.
- `quotient_in` in WIDTH: multiplier operand.
- `divisor_in` in WIDTH: multiplicand operand.
- `remainder_in` in WIDTH: addend, preloaded into the accumulator.
- `busy` in/out: out 1; high while in CALC.
- `done` out 1: high in DONE. Stays high until the next launch or reset.
- `Dividend` out 2*WIDTH: result, valid while `done` is high.
- `div_zero` out 1: the latched divisor was 0.
- `rem_err` out 1: the latched remainder was ≥ the latched divisor. Always set when `div_zero` is set.

## Operation
- Registers:
  - `start_q`: previous `start`.
  - Latched Q and D.
  - `acc`: 2*WIDTH bits.
  - `cnt`: clog2(WIDTH) bits.
  - state.
- Launch condition: `start & ~start_q` while in IDLE or DONE. A rising edge in CALC is ignored and not queued.
- States:
  - IDLE: all outputs 0. On launch go to CALC.
  - CALC: WIDTH iterations. On `cnt == WIDTH-1` go to DONE.
  - DONE: `done`=1, outputs held. On launch go to CALC and clear `done`.
- On launch edge:
  - Latch Q and D.
  - `acc <= {0, remainder_in}`, `cnt <= 0`.
  - `div_zero <= (divisor_in == 0)`, `rem_err <= (remainder_in >= divisor_in)`.
  - Clear `done`.
- Each CALC edge:
  - If `Q[0]`: `acc <= acc + ({0, D} << cnt)`.
  - `Q <= Q >> 1`, `cnt <= cnt + 1`.
- Arithmetic is unsigned with a 2*WIDTH-bit accumulator. The maximum result is 255*255 + 255 = 65280, so no overflow is possible.
- `Dividend` is driven directly from `acc` and is only guaranteed while `done`=1.
- The flags are informational only. The computation still completes; with divisor 0 the result equals the remainder.

## Timing
- Launch edge E0 enters CALC.
- Edges E1..E8 perform the 8 iterations. `done` and a valid `Dividend` appear after E8, a latency of 8 cycles from launch.
- `busy` is high from E0 through E8, i.e. for exactly WIDTH cycles.
- If `start` is held high for several cycles, only one launch occurs. `start` must return low before it can re-launch.
- Operands are sampled only at the launch edge. Changes during CALC have no effect.
- Launch from DONE discards the old result. The new result follows after 8 cycles.
- Reset:
  - `resetn`=0 at any edge, including mid-CALC, puts the block in IDLE.
  - It clears `acc`, `cnt`, `done`, `busy`, `div_zero` and `rem_err`.
  - `start_q` resets to 1, so a `start` held high through reset release does not launch.
- Reset wins over a launch occurring in the same cycle.

## Structure
- Shared package `division_pkg`:
  - `DIV_WIDTH` = 8.
  - The state enum (IDLE, CALC, DONE), shared with the divider controller.
- One sub-module, `mult_add_datapath`: holds the Q/D/`acc`/`cnt` registers plus the adder/shifter, with `load`/`step` strobes.
- The top level keeps the FSM and the start edge detector.
- Expected size: 150–250 lines total.

## Test plan
- Q=3, D=3, R=2, `start` high for 2 cycles:
  - `Dividend`=11, `div_zero`=0, `rem_err`=0.
  - `done` rises exactly 8 cycles after the launch edge.
  - Exactly one launch occurs.
- Q=0, D=128, R=7 → `Dividend`=7, `rem_err`=0. Then Q=36, D=7, R=0 → 252. Then Q=1, D=7, R=0 → 7. Run back-to-back, each launched from DONE.
- Q=255, D=255, R=255 → `Dividend`=65280, no wrap.
- D=0, Q=5, R=9 → `Dividend`=9, `div_zero`=1, `rem_err`=1. Q=2, D=4, R=4 → 12, `rem_err`=1, `div_zero`=0.
- Change operands and pulse `start` during CALC → ignored. The first result and latency are unchanged, and `busy` is high for 8 cycles.
- Assert `resetn`=0 at iteration 4 with `start` held high through release:
  - All outputs are 0.
  - No launch occurs until `start` falls and rises again.
  - The next result is correct.
